// File: rtl/alu_pkg.sv
// Shared ALU definitions: control encodings (common with the ALU control decoder),
// execute-unit FSM states and small decode helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_SLL   = 4'b0010,
    ALU_SLT   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_XOR   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(alu_ctrl_e c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle of the execute-stage ALU plus its FSM state for observation.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// the sender holds its payload stable while valid=1 and ready=0, and ready never
// depends combinationally on the same side's valid.
interface alu_exec_unit_if #(
  parameter int Width = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       control;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output in_valid, control, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy, state
  );

  modport slave (
    input  in_valid, control, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy, state
  );
endinterface

// File: rtl/alu_iter_shifter.sv
// Bit-serial shifter: loads operand and count on start, then moves one bit per cycle.
// done flags the cycle whose step is the last one; value is the post-step operand.
module alu_iter_shifter #(
  parameter int Width   = 32,
  parameter int SHAMT_W = $clog2(Width)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,    // 1 = left, 0 = right
  input  logic               arith,  // right shifts replicate the MSB
  input  logic [Width-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               done,
  output logic [Width-1:0]   value
);

  logic [Width-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;
  logic               left_q;
  logic               arith_q;

  always_comb begin
    value = '0;
    if (left_q) value = {acc[Width-2:0], 1'b0};
    else        value = {arith_q & acc[Width-1], acc[Width-1:1]};
  end

  assign done = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      acc     <= a;
      cnt     <= shamt;
      left_q  <= dir;
      arith_q <= arith;
    end else if (cnt != '0) begin
      acc <= value;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops are computed at accept, shifts run bit-serially.
// Outputs are registered; in_ready depends only on state and out_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int Width   = 32,
  parameter int SHAMT_W = $clog2(Width)
) (
  input  logic          clk,
  input  logic          rst,
  alu_exec_unit_if.slave bus
);

  alu_state_e         state;
  alu_ctrl_e          ctrl;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               take_shift;
  logic [Width-1:0]   alu_res;
  logic               alu_ill;
  logic               sh_done;
  logic [Width-1:0]   sh_value;
  logic [Width-1:0]   result_q;
  logic               zero_q;
  logic               illegal_q;

  assign ctrl       = alu_ctrl_e'(bus.control);
  assign shamt      = bus.b[SHAMT_W-1:0];
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept     = bus.in_valid & bus.in_ready;
  assign take_shift = accept & is_shift(ctrl) & (shamt != '0);

  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  // Shift codes only reach this path with shamt == 0, where the result is a.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ctrl)
      ALU_ADD:   alu_res = bus.a + bus.b;
      ALU_SUB:   alu_res = bus.a - bus.b;
      ALU_SLT:   alu_res = {{(Width-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLTU:  alu_res = {{(Width-1){1'b0}}, (bus.a < bus.b)};
      ALU_XOR:   alu_res = bus.a ^ bus.b;
      ALU_OR:    alu_res = bus.a | bus.b;
      ALU_AND:   alu_res = bus.a & bus.b;
      ALU_PASSB: alu_res = bus.b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = bus.a;
      default:   alu_ill = 1'b1;
    endcase
  end

  alu_iter_shifter #(
    .Width  (Width),
    .SHAMT_W(SHAMT_W)
  ) u_shifter (
    .clk  (clk),
    .rst  (rst),
    .start(take_shift),
    .dir  (ctrl == ALU_SLL),
    .arith(ctrl == ALU_SRA),
    .a    (bus.a),
    .shamt(shamt),
    .done (sh_done),
    .value(sh_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE with out_ready behaves like IDLE so single-cycle ops stream back to back.
          if (accept) begin
            if (take_shift) begin
              state <= SHIFT;
            end else begin
              state     <= DONE;
              result_q  <= alu_res;
              zero_q    <= (alu_res == '0);
              illegal_q <= alu_ill;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            state     <= DONE;
            result_q  <= sh_value;
            zero_q    <= (sh_value == '0);
            illegal_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns a registered result.
- Input and output sides each use a valid/ready handshake.
- Shifts run iteratively, one bit per cycle. All other operations complete in one cycle.
- Sits between decode/operand-select and the writeback/branch-compare logic of the core.

Parameters:
Width, 32, operand and result width in bits (power of 2, >= 8).
SHAMT_W, $clog2(Width), shift-amount width; taken from b[SHAMT_W-1:0].

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request this cycle
control  input  4  ALU control code (encoding below)
a  input  Width  operand A
b  input  Width  operand B / shift amount source
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
result  output  Width  operation result
zero  output  1  result == 0
illegal  output  1  control code was not a defined encoding
busy  output  1  state != IDLE

Behaviour:
- Control encoding:
  - 0000 add, 0001 sub, 0010 sll, 0011 slt (signed), 0100 sltu.
  - 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and.
  - 1010 pass-through b (U-type).
  - 1011-1111 illegal.
- Arithmetic: add/sub wrap modulo 2^Width. slt/sltu produce result 1 or 0 zero-extended. Shift amount is b[SHAMT_W-1:0]; upper bits of b are ignored.
- Acceptance: a handshake occurs when in_valid & in_ready. control, a and b are captured on that edge; later input changes are ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back throughput of one non-shift op per cycle.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on accept:
    - Non-shift op, or shift with shamt==0: compute and go to DONE. Result for shamt==0 is a.
    - Shift with shamt>0: load acc=a, cnt=shamt, go to SHIFT.
  - SHIFT: each cycle shift acc by 1 (sll: zero-fill LSB; srl: zero-fill MSB; sra: replicate MSB) and decrement cnt. When cnt reaches 0 after the step, go to DONE with result=acc. in_ready=0 throughout.
  - DONE:
    - out_valid=1; result, zero and illegal are held stable while out_ready=0.
    - out_ready & in_valid: accept the new op and follow the IDLE accept rules in the same cycle.
    - out_ready & !in_valid: go to IDLE.
- Latency: accept at edge t gives out_valid=1 from cycle t+1 for non-shift ops. For shifts it is t+1+shamt, so a 31-bit shift gives 32 cycles.
- Illegal code: result=0, zero=1, illegal=1, latency 1. It is not treated as an error stall.
- zero and illegal are registered with result and are valid only while out_valid=1.
- Reset (sync, any state including mid-shift):
  - state=IDLE, out_valid=0, result=0, zero=0, illegal=0, acc=0, cnt=0.
  - An in-flight operation is discarded with no output.
  - in_ready=1 in the cycle after reset deasserts.
- Reset has priority over simultaneous handshakes.
- No combinational path from in_valid/a/b/control to any output. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [3:0] alu_ctrl_e holding the control encodings above (shared with the ALU control decoder).
  - typedef enum for FSM states {IDLE, SHIFT, DONE}.
  - Helper function is_shift(alu_ctrl_e).
- Sub-module alu_iter_shifter: holds acc/cnt and performs the per-cycle one-bit shift.
  - Inputs: start, dir/arith, a, shamt.
  - Outputs: done, value.
- The top level owns the handshake FSM and the single-cycle datapath.

Test Plan:
1. add a=0x7FFFFFFF b=0x00000001, out_ready=1 -> out_valid one cycle after accept, result=0x80000000, zero=0, illegal=0.
2. sub a=5 b=5 -> result=0, zero=1. sltu a=1 b=0xFFFFFFFF -> 1. slt a=1 b=0xFFFFFFFF -> 0. Pass-through b=0x12345000 -> 0x12345000.
3. sra a=0x80000000 b=0x0000003F (shamt 31) -> busy, in_ready=0 for 31 cycles; out_valid exactly 32 cycles after accept, result=0xFFFFFFFF. sll a=1 b=0 -> result=1 after 1 cycle.
4. Backpressure: add completes with out_ready=0 for 3 cycles -> result/out_valid held, in_ready=0. Raise out_ready with a queued xor -> accepted that cycle, xor result valid the next cycle.
5. control=1100 -> one cycle later result=0, zero=1, illegal=1. The next legal op clears illegal.
6. srl a=0xF0000000 shamt=20, rst asserted 3 cycles after accept -> next cycle out_valid=0, busy=0, in_ready=1, result=0, and no stale completion appears afterwards.
